// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: waits for the card start bit after arming, shifts in a
// 48- or 136-bit token, checks CRC7 and the end bit, and reports timeout on a silent line.
module sd_resp_rx #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         long_resp,
  input  logic         check_crc,
  input  logic         sd_cmd,
  output logic         busy,
  output logic         done,
  output logic [135:0] resp,
  output logic         crc_err,
  output logic         end_err,
  output logic         timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECV, S_DONE} state_t;

  state_t          r_state;
  logic            r_long;
  logic            r_chk;
  logic [7:0]      r_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [6:0]      r_crc;

  logic [7:0]      w_cnt_next;
  logic [7:0]      w_len;
  logic            w_crc_on;
  logic            w_crc_fb;
  logic [6:0]      w_crc_next;
  logic [TW-1:0]   w_to_next;

  // CRC covers token bits 47..8 (short) or 127..8 (long, R2 header excluded);
  // w_cnt_next is the 1-based position of the bit being sampled.
  assign w_cnt_next = r_cnt + 8'd1;
  assign w_len      = r_long ? 8'd136 : 8'd48;
  assign w_crc_on   = (w_cnt_next <= (w_len - 8'd8)) && (!r_long || (w_cnt_next >= 8'd9));
  assign w_crc_fb   = sd_cmd ^ r_crc[6];
  assign w_crc_next = {r_crc[5:3], r_crc[2] ^ w_crc_fb, r_crc[1:0], w_crc_fb};
  assign w_to_next  = r_to_cnt + {{(TW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_long   <= 1'b0;
      r_chk    <= 1'b0;
      r_cnt    <= 8'd0;
      r_to_cnt <= '0;
      r_crc    <= 7'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      resp     <= 136'd0;
      crc_err  <= 1'b0;
      end_err  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_long   <= long_resp;
            r_chk    <= check_crc;
            r_cnt    <= 8'd0;
            r_to_cnt <= '0;
            r_crc    <= 7'd0;
            resp     <= 136'd0;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!sd_cmd) begin
            // The start bit is 0 and the CRC is still 0, so the CRC register needs no update.
            resp    <= {resp[134:0], 1'b0};
            r_cnt   <= 8'd1;
            r_state <= S_RECV;
          end else begin
            r_to_cnt <= w_to_next;
            if (w_to_next == TW'(TIMEOUT_CYCLES)) begin
              timeout <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RECV: begin
          resp  <= {resp[134:0], sd_cmd};
          r_cnt <= w_cnt_next;
          if (w_crc_on) begin
            r_crc <= w_crc_next;
          end
          if (w_cnt_next == w_len) begin
            // resp[6:0] currently holds token bits 7:1, the transmitted CRC.
            end_err <= ~sd_cmd;
            crc_err <= r_chk && (r_crc != resp[6:0]);
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed self-checking bench for sd_resp_rx: short/long responses, CRC and end-bit
// errors, timeout boundary, reset mid-reception, start ignored while busy, re-arm.
module tb_sd_resp_rx;

  logic         clk = 1'b0;
  logic         reset, start, long_resp, check_crc, sd_cmd;
  logic         busy, done, crc_err, end_err, timeout;
  logic [135:0] resp;
  int           n_checks = 0;
  int           n_fail = 0;

  sd_resp_rx #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .start(start), .long_resp(long_resp),
    .check_crc(check_crc), .sd_cmd(sd_cmd), .busy(busy), .done(done),
    .resp(resp), .crc_err(crc_err), .end_err(end_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Golden serial CRC7 (x^7+x^3+1) over tok[hi] down to tok[lo].
  function automatic logic [6:0] crc7_of(input logic [135:0] tok, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = hi; i >= lo; i--) begin
      fb = tok[i] ^ c[6];
      c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
    end
    return c;
  endfunction

  task automatic arm(input logic lng, input logic chk);
    @(negedge clk);
    start = 1'b1; long_resp = lng; check_crc = chk;
    @(negedge clk);
    start = 1'b0; long_resp = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sd_cmd = 1'b1;
    end
  endtask

  // Drives tok[len-1:0] MSB first; returns at the negedge following the end-bit edge.
  task automatic send_token(input logic [135:0] tok, input int len, input int pulse_at,
                            output logic early);
    early = 1'b0;
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge clk);
      if (done) early = 1'b1;
      start = (i == pulse_at);
      long_resp = (i == pulse_at);
      sd_cmd = tok[i];
    end
    @(negedge clk);
    start = 1'b0; long_resp = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; long_resp = 1'b0; check_crc = 1'b0; sd_cmd = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, crc_err, end_err, timeout, resp} !== 141'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", {busy, done, crc_err, end_err, timeout, resp});
    end
    reset = 1'b0;
  endtask

  task automatic test_short_good();
    logic early;
    arm(1'b0, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b required 1", busy); end
    idle(3);
    send_token(136'h400000000095, 48, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if (early !== 1'b0) begin n_fail++; $display("FAIL short_early_done: got %b required 0", early); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL short_done: got %b required 1", done); end
    n_checks++;
    if (resp !== 136'h400000000095) begin n_fail++; $display("FAIL short_resp: got %h required %h", resp, 136'h400000000095); end
    n_checks++;
    if ({crc_err, end_err, timeout, busy} !== 4'b0001) begin
      n_fail++; $display("FAIL short_flags: got %b required 0001", {crc_err, end_err, timeout, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL short_done_drop: got %b required 00", {done, busy}); end
    n_checks++;
    if (resp !== 136'h400000000095) begin n_fail++; $display("FAIL short_resp_hold: got %h required %h", resp, 136'h400000000095); end
  endtask

  task automatic test_short_errors();
    logic early;
    arm(1'b0, 1'b1); idle(2);
    send_token(136'h400000000097, 48, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({done, crc_err, end_err} !== 3'b110) begin
      n_fail++; $display("FAIL bad_crc: got %b required 110", {done, crc_err, end_err});
    end
    arm(1'b0, 1'b1); idle(1);
    send_token(136'h400000000094, 48, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({done, crc_err, end_err} !== 3'b101) begin
      n_fail++; $display("FAIL bad_end: got %b required 101", {done, crc_err, end_err});
    end
    arm(1'b0, 1'b0); idle(1);
    send_token(136'h400000000097, 48, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({done, crc_err, end_err} !== 3'b100) begin
      n_fail++; $display("FAIL crc_disabled: got %b required 100", {done, crc_err, end_err});
    end
  endtask

  task automatic test_long();
    logic [119:0] cid;
    logic [135:0] tok;
    logic         early;
    cid = 120'h0123456789ABCDEF_FEDCBA98765432;
    tok = {8'h3F, cid, 7'd0, 1'b1};
    tok[7:1] = crc7_of(tok, 127, 8);
    arm(1'b1, 1'b1); idle(4);
    send_token(tok, 136, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({early, done} !== 2'b01) begin n_fail++; $display("FAIL long_done_timing: got %b required 01", {early, done}); end
    n_checks++;
    if (resp !== tok) begin n_fail++; $display("FAIL long_resp: got %h required %h", resp, tok); end
    n_checks++;
    if ({crc_err, end_err, timeout} !== 3'b000) begin
      n_fail++; $display("FAIL long_flags: got %b required 000", {crc_err, end_err, timeout});
    end
    tok[60] = ~tok[60];
    arm(1'b1, 1'b1); idle(1);
    send_token(tok, 136, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({done, crc_err, end_err} !== 3'b110) begin
      n_fail++; $display("FAIL long_bad_cid: got %b required 110", {done, crc_err, end_err});
    end
  endtask

  task automatic test_timeout();
    logic early;
    int   seen;
    // Line held high through edge k+64.
    arm(1'b0, 1'b1);
    repeat (63) @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b required 0", done); end
    @(negedge clk);
    n_checks++;
    if ({done, timeout, busy} !== 3'b111) begin
      n_fail++; $display("FAIL timeout_hold: got %b required 111", {done, timeout, busy});
    end
    n_checks++;
    if (resp !== 136'd0) begin n_fail++; $display("FAIL timeout_resp: got %h required 0", resp); end
    // Start bit sampled exactly at edge k+64.
    @(negedge clk);
    arm(1'b0, 1'b1); idle(62);
    send_token(136'h400000000095, 48, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({early, done, timeout, crc_err, end_err} !== 5'b01000) begin
      n_fail++; $display("FAIL start_at_64: got %b required 01000", {early, done, timeout, crc_err, end_err});
    end
    n_checks++;
    if (resp !== 136'h400000000095) begin n_fail++; $display("FAIL start_at_64_resp: got %h required %h", resp, 136'h400000000095); end
    // Start bit at edge k+65 arrives too late.
    @(negedge clk);
    arm(1'b0, 1'b1); idle(63);
    @(negedge clk);
    n_checks++;
    if ({done, timeout} !== 2'b11) begin n_fail++; $display("FAIL start_at_65: got %b required 11", {done, timeout}); end
    sd_cmd = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      sd_cmd = (i < 10) ? 1'b0 : 1'b1;
      if (done) seen++;
    end
    n_checks++;
    if ({seen[3:0], busy, resp[3:0]} !== 9'd0) begin
      n_fail++; $display("FAIL start_at_65_after: got done=%0d busy=%b resp=%h required 0", seen, busy, resp);
    end
  endtask

  task automatic test_reset_mid();
    logic [135:0] tok;
    int           seen;
    tok = 136'h400000000095;
    arm(1'b0, 1'b1); idle(2);
    for (int i = 47; i >= 28; i--) begin
      @(negedge clk);
      sd_cmd = tok[i];
    end
    @(negedge clk);
    reset = 1'b1;
    sd_cmd = tok[27];
    @(negedge clk);
    n_checks++;
    if ({busy, done, crc_err, end_err, timeout, resp} !== 141'd0) begin
      n_fail++; $display("FAIL reset_mid: got %h required 0", {busy, done, crc_err, end_err, timeout, resp});
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 26; i >= -6; i--) begin
      @(negedge clk);
      sd_cmd = (i >= 0) ? tok[i] : 1'b1;
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_done: got done=%0d busy=%b required 0 0", seen, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic early;
    arm(1'b0, 1'b1); idle(1);
    send_token(136'h400000000095, 48, 20, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({early, done, crc_err, end_err} !== 4'b0100) begin
      n_fail++; $display("FAIL start_in_recv: got %b required 0100", {early, done, crc_err, end_err});
    end
    n_checks++;
    if (resp !== 136'h400000000095) begin n_fail++; $display("FAIL start_in_recv_resp: got %h required %h", resp, 136'h400000000095); end
    arm(1'b0, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rearm_busy: got %b required 1", busy); end
    idle(2);
    send_token(136'h48000001AA87, 48, -1, early);
    sd_cmd = 1'b1;
    n_checks++;
    if ({done, crc_err, end_err, timeout} !== 4'b1000) begin
      n_fail++; $display("FAIL rearm_flags: got %b required 1000", {done, crc_err, end_err, timeout});
    end
    n_checks++;
    if (resp !== 136'h48000001AA87) begin n_fail++; $display("FAIL rearm_resp: got %h required %h", resp, 136'h48000001AA87); end
  endtask

  initial begin
    test_reset();
    test_short_good();
    test_short_errors();
    test_long();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
